// File: rtl/fpaddsub_exception_stage_if.sv
// rtl/fpaddsub_exception_stage_if.sv - operand/result handshake bundle for the add/sub exception stage
interface fpaddsub_exception_stage_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   logic                   in_valid;
   logic                   in_ready;
   logic [EXP_W:0]         round_e;
   logic [MAN_W-1:0]       round_m;
   logic                   sa;
   logic                   sb;
   logic                   max_ab;
   logic [6:0]             input_exc;
   logic [MAN_W-1:0]       mqnan;
   logic                   p_inexact;
   logic                   zero_sum;
   logic                   neg_e;
   logic                   opr;
   logic [2:0]             ctrl;
   logic                   out_valid;
   logic                   out_ready;
   logic [EXP_W+MAN_W:0]   z;
   logic [4:0]             flags;

   modport master (
      output in_valid, round_e, round_m, sa, sb, max_ab, input_exc, mqnan,
             p_inexact, zero_sum, neg_e, opr, ctrl, out_ready,
      input  in_ready, out_valid, z, flags
   );

   modport slave (
      input  in_valid, round_e, round_m, sa, sb, max_ab, input_exc, mqnan,
             p_inexact, zero_sum, neg_e, opr, ctrl, out_ready,
      output in_ready, out_valid, z, flags
   );
endinterface

// File: rtl/fpaddsub_exception_stage.sv
// rtl/fpaddsub_exception_stage.sv - final add/sub stage: special-case result select, IEEE flags, sticky flags and trap
module fpaddsub_exception_stage #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                      clk,
   input  logic                      rst,
   fpaddsub_exception_stage_if.slave bus,
   input  logic                      flag_clr,
   input  logic [4:0]                trap_en,
   output logic [4:0]                sticky_flags,
   output logic                      irq
);
   typedef enum logic [1:0] {RM_RNE = 2'b00, RM_RTZ = 2'b01, RM_RUP = 2'b10, RM_RDN = 2'b11} rm_t;

   localparam logic [EXP_W-1:0] EMAX    = {EXP_W{1'b1}};
   localparam logic [EXP_W-1:0] EMAX_M1 = {{(EXP_W-1){1'b1}}, 1'b0};

   logic                 out_valid_q;
   logic [EXP_W+MAN_W:0] z_q;
   logic [4:0]           flags_q;
   logic [4:0]           sticky_q;
   logic                 irq_q;

   rm_t                  rm;
   logic                 exp_of;
   logic                 invalid;
   logic                 overflow;
   logic                 underflow;
   logic                 inexact;
   logic                 pfs;
   logic                 s;
   logic                 sat_max;
   logic                 load;
   logic [EXP_W+MAN_W:0] z_next;
   logic [4:0]           flags_next;
   logic [4:0]           sticky_next;

   assign bus.in_ready  = ~out_valid_q | bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.z         = z_q;
   assign bus.flags     = flags_q;
   assign sticky_flags  = sticky_q;
   assign irq           = irq_q;

   assign load = bus.in_valid & bus.in_ready;

   always_comb begin
      rm        = rm_t'(bus.ctrl[2:1]);
      exp_of    = bus.round_e[EXP_W] | (&bus.round_e[EXP_W-1:0]);
      invalid   = bus.input_exc[3] | bus.input_exc[4] |
                  (bus.input_exc[5] & bus.input_exc[6] & bus.opr);
      overflow  = exp_of & ~bus.neg_e & ~bus.zero_sum & ~bus.input_exc[0];
      underflow = bus.neg_e & ~bus.input_exc[0];
      inexact   = bus.p_inexact | overflow;
      flags_next = {overflow, underflow, 1'b0, invalid, inexact};

      // An exact zero is negative only for -a + -b, or under round-down with mixed signs
      if (bus.zero_sum)
         pfs = bus.sa & bus.sb & ~bus.ctrl[0];
      else
         pfs = (~bus.max_ab & bus.sa) | ((bus.ctrl[0] ^ bus.sb) & (bus.max_ab | bus.sa));
      s = pfs | ((rm == RM_RDN) & (bus.sa ^ bus.sb));

      // Overflow saturates to max finite when the rounding direction points toward zero
      sat_max = (rm == RM_RTZ) | ((rm == RM_RUP) & s) | ((rm == RM_RDN) & ~s);

      if (invalid)
         z_next = {1'b0, EMAX, bus.mqnan};
      else if (bus.input_exc[1] | bus.input_exc[2])
         z_next = {1'b0, EMAX, bus.mqnan};
      else if (bus.input_exc[0])
         z_next = {s, EMAX, {MAN_W{1'b0}}};
      else if (overflow)
         z_next = sat_max ? {s, EMAX_M1, {MAN_W{1'b1}}} : {s, EMAX, {MAN_W{1'b0}}};
      else if (underflow | bus.zero_sum)
         z_next = {s, {EXP_W{1'b0}}, {MAN_W{1'b0}}};
      else
         z_next = {s, bus.round_e[EXP_W-1:0], bus.round_m};

      if (flag_clr)
         sticky_next = load ? flags_next : 5'b0;
      else
         sticky_next = load ? (sticky_q | flags_next) : sticky_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         z_q         <= '0;
         flags_q     <= 5'b0;
         sticky_q    <= 5'b0;
         irq_q       <= 1'b0;
      end else begin
         if (load) begin
            out_valid_q <= 1'b1;
            z_q         <= z_next;
            flags_q     <= flags_next;
         end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         sticky_q <= sticky_next;
         irq_q    <= |(sticky_next & trap_en);
      end
   end
endmodule

// File: tb/tb_fpaddsub_exception_stage.sv
// tb/tb_fpaddsub_exception_stage.sv - vector table plus scoreboard bench for the add/sub exception stage
module tb_fpaddsub_exception_stage;
   typedef struct {
      logic [8:0]  round_e;
      logic [22:0] round_m;
      logic        sa;
      logic        sb;
      logic        max_ab;
      logic [6:0]  input_exc;
      logic [22:0] mqnan;
      logic        p_inexact;
      logic        zero_sum;
      logic        neg_e;
      logic        opr;
      logic [2:0]  ctrl;
      logic [31:0] ez;
      logic [4:0]  ef;
   } vec_t;

   typedef struct {
      logic [31:0] z;
      logic [4:0]  f;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flag_clr = 1'b0;
   logic [4:0] trap_en = 5'b0;
   logic [4:0] sticky_flags;
   logic       irq;

   int checks = 0;
   int errors = 0;

   vec_t        tbl[17];
   exp_t        q[$];
   logic [31:0] cur_ez = '0;
   logic [4:0]  cur_ef = '0;
   logic        ov_m = 1'b0;
   logic [4:0]  sm = 5'b0;
   logic        im = 1'b0;

   fpaddsub_exception_stage_if #(.EXP_W(8), .MAN_W(23)) bus ();

   fpaddsub_exception_stage #(.EXP_W(8), .MAN_W(23)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .flag_clr     (flag_clr),
      .trap_en      (trap_en),
      .sticky_flags (sticky_flags),
      .irq          (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.round_e   = v.round_e;
      bus.round_m   = v.round_m;
      bus.sa        = v.sa;
      bus.sb        = v.sb;
      bus.max_ab    = v.max_ab;
      bus.input_exc = v.input_exc;
      bus.mqnan     = v.mqnan;
      bus.p_inexact = v.p_inexact;
      bus.zero_sum  = v.zero_sum;
      bus.neg_e     = v.neg_e;
      bus.opr       = v.opr;
      bus.ctrl      = v.ctrl;
      cur_ez        = v.ez;
      cur_ef        = v.ef;
   endtask

   task automatic send(input vec_t v);
      int n;
      bit done;
      drive(v);
      bus.in_valid = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) done = 1'b1;
         else if (++n > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready stuck at 0 after %0d cycles", n);
            done = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
   endtask

   // Reference model of the handshake and sticky/irq state, plus the result scoreboard
   always @(negedge clk) begin
      logic       ld;
      logic       exp_rdy;
      logic [4:0] sm_n;
      exp_t       e;
      if (rst) begin
         q.delete();
         ov_m = 1'b0;
         sm   = 5'b0;
         im   = 1'b0;
      end else begin
         exp_rdy = ~ov_m | bus.out_ready;
         chk("out_valid", 32'(bus.out_valid), 32'(ov_m));
         chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
         chk("sticky_flags", 32'(sticky_flags), 32'(sm));
         chk("irq", 32'(irq), 32'(im));
         ld = bus.in_valid & exp_rdy;
         if (ov_m & bus.out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow output transfer with no expected result");
            end else begin
               e = q.pop_front();
               chk("z", bus.z, e.z);
               chk("flags", 32'(bus.flags), 32'(e.f));
            end
         end
         if (ld) q.push_back('{z: cur_ez, f: cur_ef});
         if (flag_clr) sm_n = ld ? cur_ef : 5'b0;
         else          sm_n = ld ? (sm | cur_ef) : sm;
         sm   = sm_n;
         im   = |(sm_n & trap_en);
         ov_m = ld ? 1'b1 : (bus.out_ready ? 1'b0 : ov_m);
      end
   end

   initial begin
      //          round_e  round_m      sa    sb    mab   exc         mqnan        pin   zs    nege  opr   ctrl    z             flags
      tbl[0]  = '{9'h080, 23'h000000, 1'b0, 1'b0, 1'b0, 7'b0000000, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h40000000, 5'b00000};
      tbl[1]  = '{9'h0FF, 23'h000000, 1'b0, 1'b0, 1'b0, 7'b0000000, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h7F800000, 5'b10001};
      tbl[2]  = '{9'h0FF, 23'h000000, 1'b0, 1'b0, 1'b0, 7'b0000000, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 32'h7F7FFFFF, 5'b10001};
      tbl[3]  = '{9'h0FF, 23'h000000, 1'b1, 1'b1, 1'b0, 7'b0000000, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 32'hFF7FFFFF, 5'b10001};
      tbl[4]  = '{9'h0FF, 23'h000000, 1'b0, 1'b0, 1'b0, 7'b0000000, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 32'h7F7FFFFF, 5'b10001};
      tbl[5]  = '{9'h0FF, 23'h000000, 1'b0, 1'b0, 1'b0, 7'b0000000, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 32'h7F800000, 5'b10001};
      tbl[6]  = '{9'h000, 23'h000000, 1'b0, 1'b0, 1'b0, 7'b1100001, 23'h400000, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h7FC00000, 5'b00010};
      tbl[7]  = '{9'h000, 23'h000000, 1'b0, 1'b1, 1'b0, 7'b0000000, 23'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 32'h80000000, 5'b00000};
      tbl[8]  = '{9'h000, 23'h000000, 1'b0, 1'b1, 1'b0, 7'b0000000, 23'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h00000000, 5'b00000};
      tbl[9]  = '{9'h001, 23'h000000, 1'b1, 1'b1, 1'b0, 7'b0000000, 23'h000000, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'h80000000, 5'b01001};
      tbl[10] = '{9'h000, 23'h000000, 1'b0, 1'b0, 1'b0, 7'b0000011, 23'h400000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h7FC00000, 5'b00000};
      tbl[11] = '{9'h000, 23'h000000, 1'b0, 1'b0, 1'b0, 7'b0010001, 23'h600000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h7FE00000, 5'b00010};
      tbl[12] = '{9'h000, 23'h000000, 1'b1, 1'b0, 1'b0, 7'b0100001, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'hFF800000, 5'b00000};
      tbl[13] = '{9'h07F, 23'h123456, 1'b0, 1'b0, 1'b1, 7'b0000000, 23'h000000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 32'hBF923456, 5'b00001};
      tbl[14] = '{9'h100, 23'h000000, 1'b0, 1'b0, 1'b0, 7'b0000000, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h7F800000, 5'b10001};
      tbl[15] = '{9'h000, 23'h000000, 1'b1, 1'b1, 1'b0, 7'b0000000, 23'h000000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'h80000000, 5'b00000};
      tbl[16] = '{9'h000, 23'h000000, 1'b0, 1'b0, 1'b0, 7'b1100001, 23'h000000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h7F800000, 5'b00000};

      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      drive(tbl[0]);

      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_z", bus.z, 32'h0);
      chk("rst_flags", 32'(bus.flags), 32'h0);
      chk("rst_sticky", 32'(sticky_flags), 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
      rst = 1'b0;

      send(tbl[0]);
      chk("normal_latency_valid", 32'(bus.out_valid), 32'h1);
      chk("normal_latency_z", bus.z, 32'h40000000);
      for (int i = 1; i < 17; i++) send(tbl[i]);
      drain();

      // Back-pressure: one result held while the next waits at the input
      bus.out_ready = 1'b0;
      send(tbl[1]);
      drive(tbl[6]);
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 32'(bus.in_ready), 32'h0);
         chk("bp_z_hold", bus.z, 32'h7F800000);
         chk("bp_flags_hold", 32'(bus.flags), 32'(5'b10001));
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      chk("bp_passthrough_z", bus.z, 32'h7FC00000);
      drain();

      // Sticky clear and trap
      trap_en  = 5'b00010;
      flag_clr = 1'b1;
      @(posedge clk);
      #1;
      flag_clr = 1'b0;
      chk("clr_idle_sticky", 32'(sticky_flags), 32'h0);
      chk("clr_idle_irq", 32'(irq), 32'h0);
      send(tbl[1]);
      chk("ovf_sticky", 32'(sticky_flags), 32'(5'b10001));
      chk("ovf_irq_masked", 32'(irq), 32'h0);
      flag_clr = 1'b1;
      send(tbl[6]);
      flag_clr = 1'b0;
      chk("clr_load_sticky", 32'(sticky_flags), 32'(5'b00010));
      chk("clr_load_irq", 32'(irq), 32'h1);
      trap_en = 5'b00000;
      @(posedge clk);
      #1;
      chk("trap_off_irq", 32'(irq), 32'h0);
      drain();

      // Asynchronous reset with a result held under back-pressure
      trap_en = 5'b00011;
      bus.out_ready = 1'b0;
      send(tbl[13]);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("arst_z", bus.z, 32'h0);
      chk("arst_flags", 32'(bus.flags), 32'h0);
      chk("arst_sticky", 32'(sticky_flags), 32'h0);
      chk("arst_irq", 32'(irq), 32'h0);
      chk("arst_in_ready", 32'(bus.in_ready), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      send(tbl[9]);
      drain();
      @(posedge clk);
      #1;
      chk("sb_empty", 32'(q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
